// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared widths and requester IDs for the writeback arbiter
package regfile_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 8;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-register scoreboard with RAW hazard lookup
module wb_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int NREGS  = regfile_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_dest_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_dest_i,
    input  logic [ADDR_W-1:0] chk_addr_1_i,
    input  logic [ADDR_W-1:0] chk_addr_2_i,
    output logic              hazard_o,
    output logic [NREGS-1:0]  pending_o
);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Set is applied after clear so a newly issued producer stays outstanding.
    always_comb begin
        pending_d = pending_q;
        if (clr_en_i) begin
            pending_d[clr_dest_i] = 1'b0;
        end
        if (set_en_i) begin
            pending_d[set_dest_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign hazard_o  = pending_q[chk_addr_1_i] | pending_q[chk_addr_2_i];
    assign pending_o = pending_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin share of the register file write port
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int NREGS  = regfile_pkg::NREGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_dest,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_dest,
    input  logic [DATA_W-1:0] b_data,
    output logic              reg_write_en,
    output logic [ADDR_W-1:0] reg_write_dest,
    output logic [DATA_W-1:0] reg_write_data,
    input  logic              sb_set_en,
    input  logic [ADDR_W-1:0] sb_set_dest,
    input  logic [ADDR_W-1:0] chk_addr_1,
    input  logic [ADDR_W-1:0] chk_addr_2,
    output logic              hazard,
    output logic [NREGS-1:0]  pending
);

    req_id_e           last_grant_q;
    logic              wen_q;
    logic [ADDR_W-1:0] wdest_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant_a;
    logic              grant_b;

    // Under contention the port that did not win last time gets the grant.
    always_comb begin
        grant_a = a_valid & (~b_valid | (last_grant_q == REQ_B));
        grant_b = b_valid & (~a_valid | (last_grant_q == REQ_A));
    end

    assign a_ready = grant_a;
    assign b_ready = grant_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= REQ_B;
            wen_q        <= 1'b0;
            wdest_q      <= '0;
            wdata_q      <= '0;
        end else begin
            wen_q <= grant_a | grant_b;
            if (grant_a) begin
                last_grant_q <= REQ_A;
                wdest_q      <= a_dest;
                wdata_q      <= a_data;
            end else if (grant_b) begin
                last_grant_q <= REQ_B;
                wdest_q      <= b_dest;
                wdata_q      <= b_data;
            end
        end
    end

    assign reg_write_en   = wen_q;
    assign reg_write_dest = wdest_q;
    assign reg_write_data = wdata_q;

    wb_scoreboard #(
        .ADDR_W(ADDR_W),
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en_i    (sb_set_en),
        .set_dest_i  (sb_set_dest),
        .clr_en_i    (wen_q),
        .clr_dest_i  (wdest_q),
        .chk_addr_1_i(chk_addr_1),
        .chk_addr_2_i(chk_addr_2),
        .hazard_o    (hazard),
        .pending_o   (pending)
    );

endmodule
